// File: rtl/nibble_add_seq.sv
// nibble_add_seq: wide adder built from one 4-bit ripple-carry slice.
// The slice is reused once per clock, least-significant nibble first, and a
// registered carry links the nibbles. Operands are taken through a start
// valid/ready handshake and the result is offered through a done handshake.
//
// Optional feature: define NIBBLE_ADD_SEQ_SUB_EN to honour `op` (1 = subtract,
// computed as a + ~b + 1). Without it `op` is ignored, and the B path has no
// inverter or mux.

module nibble_add_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  input  logic                 op,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done_valid,
  input  logic                 done_ready
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;       // effective B, already inverted for subtract
  logic            carry_q, carry_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            c_out_q, c_out_d;
  logic            overflow_q, overflow_d;

  logic [W-1:0]    b_eff;
  logic            cin_eff;
  logic [IdxW+1:0] nib_base;
  logic [3:0]      a_nib, b_nib;
  logic [3:0]      slice_sum;
  logic            slice_cout;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  // Subtract is a + ~b + 1: invert B and force the carry-in.
  assign b_eff   = op ? ~b : b;
  assign cin_eff = op ? 1'b1 : c_in;
`else
  logic unused_op;
  assign unused_op = op;
  assign b_eff     = b;
  assign cin_eff   = c_in;
`endif

  // Bit offset of the nibble currently being processed.
  assign nib_base = {idx_q, 2'b00};
  assign a_nib    = a_q[nib_base +: 4];
  assign b_nib    = b_q[nib_base +: 4];

  // Shared 4-bit ripple-carry slice: four full-adder cells.
  always_comb begin
    logic [4:0] chain;
    chain      = '0;
    slice_sum  = '0;
    chain[0]   = carry_q;
    for (int i = 0; i < 4; i++) begin
      slice_sum[i] = a_nib[i] ^ b_nib[i] ^ chain[i];
      chain[i+1]   = (a_nib[i] & b_nib[i]) | (chain[i] & (a_nib[i] ^ b_nib[i]));
    end
    slice_cout = chain[4];
  end

  // Next-state logic: accept, per-nibble accumulate, and result hand-off.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;

    case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_d        = a;
          b_d        = b_eff;
          carry_d    = cin_eff;
          sum_d      = '0;
          c_out_d    = 1'b0;
          overflow_d = 1'b0;
          idx_d      = '0;
          state_d    = StRun;
        end
      end
      StRun: begin
        sum_d[nib_base +: 4] = slice_sum;
        carry_d              = slice_cout;
        idx_d                = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          c_out_d    = slice_cout;
          // Uses the freshly written top nibble, so read sum_d not sum_q.
          overflow_d = (a_q[W-1] == b_q[W-1]) & (sum_d[W-1] != a_q[W-1]);
          idx_d      = '0;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (done_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      sum_q      <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs come only from registers or state decode.
  assign start_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign done_valid  = (state_q == StDone);
  assign sum         = sum_q;
  assign c_out       = c_out_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Sequencer that performs a wide add of two `4*NIBBLES`-bit operands by reusing a single 4-bit ripple-carry adder slice (four full-adder cells) once per clock, least-significant nibble first. A registered carry links consecutive nibbles. Operands enter through a valid/ready start handshake and results leave through a valid/ready done handshake. The block sits between switch/register-driven operand sources and display or downstream logic, trading latency for adder area.

## Interface

- `NIBBLES`, default 4: number of 4-bit slices per operation; operand width `W = 4*NIBBLES`. Legal range is 1..8.

- `clock`, in, 1: single rising-edge clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `start_valid`, in, 1: requester offers an operation.
- `start_ready`, out, 1: block accepts an operation. High only in IDLE.
- `a`, in, W: operand A. Sampled at the accept edge.
- `b`, in, W: operand B. Sampled at the accept edge.
- `c_in`, in, 1: carry-in for an add. Sampled at the accept edge.
- `op`, in, 1: 0 = add, 1 = subtract. Only honoured when `NIBBLE_ADD_SEQ_SUB_EN` is defined.
- `sum`, out, W: result register.
- `c_out`, out, 1: carry out of bit W-1.
- `overflow`, out, 1: two's-complement signed overflow.
- `busy`, out, 1: high in RUN and DONE.
- `done_valid`, out, 1: result available. High only in DONE.
- `done_ready`, in, 1: consumer takes the result.

## Operation

- **Accept:** an operation is accepted on a rising edge where `start_valid & start_ready`. At that edge:
  - Latch `a` and the effective B (`b`, or `~b` when subtracting).
  - Load the carry register with `c_in` (or 1 when subtracting).
  - Clear `sum`, `c_out` and `overflow` to 0.
  - Set nibble index to 0 and go to RUN.
- **States:**
  - IDLE: `start_ready`=1, `busy`=0, `done_valid`=0. Moves to RUN on accept.
  - RUN: each edge feeds nibble `idx` of A and effective B, plus the carry register, to the 4-bit slice.
    - The slice result is written to `sum[4*idx+3:4*idx]`.
    - The slice carry-out is written to the carry register, and `idx` increments.
    - On the edge processing `idx = NIBBLES-1`: `c_out` gets the slice carry-out, `overflow` is computed, and the state goes to DONE.
  - DONE: `done_valid`=1. `sum`, `c_out` and `overflow` are held stable. Moves to IDLE on an edge with `done_ready`=1.
- **Overflow:** `overflow = (A[W-1] == Beff[W-1]) & (sum[W-1] != A[W-1])`, where Beff is the effective B after any inversion.
- **Arithmetic:** modulo 2^W. `c_out` is the true carry out of the full W-bit sum.
- **Ignored inputs:**
  - `start_valid` in RUN or DONE is ignored (`start_ready`=0). There is no queueing.
  - Operand inputs are don't-care outside the accept edge.
- **Results in IDLE:** after completion, `sum`, `c_out` and `overflow` keep the last result until the next accept clears them.
- **`NIBBLES`=1:** RUN lasts exactly one edge.

## Timing

- **Reset:** `resetn` low forces IDLE immediately, without waiting for a clock. All registers clear:
  - `sum`=0, `c_out`=0, `overflow`=0.
  - `done_valid`=0, `busy`=0, `start_ready`=1.
- **Reset mid-operation:** reset asserted in RUN or DONE abandons the operation. No partial result is retained.
- **Latency:** with the accept edge as edge 0, nibble k is processed on edge k+1. `done_valid` rises after edge `NIBBLES`.
- **Throughput:** the DONE→IDLE transition costs one edge, so the next accept can occur at the earliest on the edge after that. Minimum period is `NIBBLES+2` clocks per operation.
- **Backpressure:** while `done_ready`=0, DONE is held indefinitely with outputs frozen.
- **Output timing:** all outputs are registered or decoded from state only. There are no combinational input→output paths.

## Configuration

- **`NIBBLE_ADD_SEQ_SUB_EN` defined:** `op`=1 computes `a - b` as `a + ~b + 1`.
  - `c_in` is ignored for this operation.
  - `c_out`=1 means no borrow.
  - `overflow` follows the same formula using Beff=`~b`.
- **Not defined:** `op` is ignored and every operation is `a + b + c_in`. No inverter or mux is generated on the B path.

## Test plan

All cases use `NIBBLES`=4.

1. **Basic add:** `a`=16'h1234, `b`=16'h1111, `c_in`=0 → `sum`=16'h2345, `c_out`=0, `overflow`=0. `done_valid` high after edge 4 following accept.
2. **Full carry ripple:** `a`=16'hFFFF, `b`=16'h0001, `c_in`=0 → `sum`=16'h0000, `c_out`=1, `overflow`=0. The carry propagates through all four nibble steps. Repeat with `c_in`=1 and `b`=0 → same result.
3. **Signed overflow:** `a`=16'h7FFF, `b`=16'h0001 → `sum`=16'h8000, `c_out`=0, `overflow`=1.
4. **Backpressure:** hold `done_ready`=0 for 6 clocks after `done_valid` with `start_valid`=1 and changing `a`/`b`.
   - Required: `start_ready`=0, outputs frozen, no new accept.
   - Then `done_ready`=1 → IDLE next edge, and the pending start is accepted the edge after.
5. **Reset mid-RUN:** assert `resetn`=0 after edge 2 of RUN.
   - Required: all outputs at reset values immediately, without waiting for a clock.
   - After release, a new `a`=16'h00FF, `b`=16'h0001 op yields `sum`=16'h0100.
6. **Subtract (with `NIBBLE_ADD_SEQ_SUB_EN` only):** `op`=1, `a`=16'h0005, `b`=16'h0007 → `sum`=16'hFFFE, `c_out`=0, `overflow`=0.
   - Also `a`=16'h8000, `b`=16'h0001 → `sum`=16'h7FFF, `c_out`=1, `overflow`=1.
   - Without the macro, the first case yields `sum`=16'h000C.
